// File: rtl/vga_sync_to_count.sv
// vga_sync_to_count: recovers column/row coordinates from incoming VGA sync
// pulses, re-times the syncs to match, and verifies line/frame periods.
module vga_sync_to_count #(
  parameter int TOTAL_COLS  = 800,
  parameter int TOTAL_ROWS  = 525,
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       H_Sync,
  input  logic       V_Sync,
  output logic       H_Sync_Out,
  output logic       V_Sync_Out,
  output logic [9:0] Col_Count,
  output logic [9:0] Row_Count,
  output logic       Active,
  output logic       Locked,
  output logic       Timing_Err
);

  localparam logic [9:0] COL_LAST = 10'(TOTAL_COLS - 1);
  localparam logic [9:0] ROW_LAST = 10'(TOTAL_ROWS - 1);
  localparam logic [9:0] ACT_COLS = 10'(ACTIVE_COLS);
  localparam logic [9:0] ACT_ROWS = 10'(ACTIVE_ROWS);
  localparam logic [9:0] CNT_MAX  = 10'd1023;
  localparam logic [3:0] LOCK_TGT = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCK    = 2'd2
  } state_t;

  logic       h_d1_r, h_d2_r, v_d1_r, v_d2_r;
  logic       h_seen_r, frame_err_r;
  state_t     state_r, state_nx_s;
  logic [3:0] good_cnt_r, good_cnt_nx_s;
  logic       h_rise_s, v_rise_s, line_err_s, frame_bad_s, err_s;
  logic       locked_nx_s, timing_err_nx_s;

  assign h_rise_s    = h_d1_r & ~h_d2_r;
  assign v_rise_s    = v_d1_r & ~v_d2_r;
  assign line_err_s  = h_rise_s & h_seen_r & (Col_Count != COL_LAST);
  assign frame_bad_s = v_rise_s & ((Row_Count != ROW_LAST) | frame_err_r);
  assign err_s       = line_err_s | frame_bad_s;
  assign Active      = Locked & (Col_Count < ACT_COLS) & (Row_Count < ACT_ROWS);

  // Sync re-timing pipeline, saturating coordinate counters and line bookkeeping
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      h_d1_r      <= 1'b1;
      h_d2_r      <= 1'b1;
      v_d1_r      <= 1'b1;
      v_d2_r      <= 1'b1;
      H_Sync_Out  <= 1'b1;
      V_Sync_Out  <= 1'b1;
      Col_Count   <= 10'd0;
      Row_Count   <= 10'd0;
      h_seen_r    <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      h_d1_r     <= H_Sync;
      h_d2_r     <= h_d1_r;
      v_d1_r     <= V_Sync;
      v_d2_r     <= v_d1_r;
      H_Sync_Out <= h_d1_r;
      V_Sync_Out <= v_d1_r;
      if (h_rise_s) begin
        Col_Count <= 10'd0;
      end else if (Col_Count != CNT_MAX) begin
        Col_Count <= Col_Count + 10'd1;
      end else begin
        Col_Count <= Col_Count;
      end
      // A frame start zeroes the row even when a line start lands on the same cycle
      if (v_rise_s) begin
        Row_Count <= 10'd0;
      end else if (h_rise_s && (Row_Count != CNT_MAX)) begin
        Row_Count <= Row_Count + 10'd1;
      end else begin
        Row_Count <= Row_Count;
      end
      if (h_rise_s) begin
        h_seen_r <= 1'b1;
      end else begin
        h_seen_r <= h_seen_r;
      end
      if (v_rise_s) begin
        frame_err_r <= 1'b0;
      end else if (line_err_s) begin
        frame_err_r <= 1'b1;
      end else begin
        frame_err_r <= frame_err_r;
      end
    end
  end

  // Lock FSM state and registered status outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r    <= SEARCH;
      good_cnt_r <= 4'd0;
      Locked     <= 1'b0;
      Timing_Err <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      good_cnt_r <= good_cnt_nx_s;
      Locked     <= locked_nx_s;
      Timing_Err <= timing_err_nx_s;
    end
  end

  // Lock FSM next-state: count consecutive good frames, fall back on any error
  always_comb begin
    state_nx_s    = state_r;
    good_cnt_nx_s = good_cnt_r;
    case (state_r)
      SEARCH: begin
        if (v_rise_s) begin
          state_nx_s    = ACQUIRE;
          good_cnt_nx_s = 4'd0;
        end else begin
          state_nx_s    = SEARCH;
        end
      end
      ACQUIRE: begin
        if (err_s) begin
          good_cnt_nx_s = 4'd0;
        end else if (v_rise_s) begin
          if ((good_cnt_r + 4'd1) >= LOCK_TGT) begin
            state_nx_s    = LOCK;
            good_cnt_nx_s = 4'd0;
          end else begin
            good_cnt_nx_s = good_cnt_r + 4'd1;
          end
        end else begin
          good_cnt_nx_s = good_cnt_r;
        end
      end
      LOCK: begin
        if (err_s) begin
          state_nx_s    = ACQUIRE;
          good_cnt_nx_s = 4'd0;
        end else begin
          state_nx_s    = LOCK;
        end
      end
      default: begin
        state_nx_s    = SEARCH;
        good_cnt_nx_s = 4'd0;
      end
    endcase
  end

  // Status decode; errors seen while still searching are not reported
  always_comb begin
    locked_nx_s     = 1'b0;
    timing_err_nx_s = 1'b0;
    if (state_nx_s == LOCK) begin
      locked_nx_s = 1'b1;
    end else begin
      locked_nx_s = 1'b0;
    end
    if (err_s && (state_r != SEARCH)) begin
      timing_err_nx_s = 1'b1;
    end else begin
      timing_err_nx_s = 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_sync_to_count.sv
// Randomised scoreboard bench for vga_sync_to_count using a small-frame
// timing (10 clocks x 6 lines) and an event-based reference model.
module tb_vga_sync_to_count;

  localparam int TC = 10;
  localparam int AC = 6;
  localparam int TR = 6;
  localparam int AR = 4;
  localparam int LF = 2;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       H_Sync = 1'b1;
  logic       V_Sync = 1'b1;
  logic       H_Sync_Out, V_Sync_Out, Active, Locked, Timing_Err;
  logic [9:0] Col_Count, Row_Count;

  vga_sync_to_count #(
    .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC),
    .ACTIVE_ROWS(AR), .LOCK_FRAMES(LF)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .H_Sync(H_Sync), .V_Sync(V_Sync),
    .H_Sync_Out(H_Sync_Out), .V_Sync_Out(V_Sync_Out),
    .Col_Count(Col_Count), .Row_Count(Row_Count),
    .Active(Active), .Locked(Locked), .Timing_Err(Timing_Err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         n;
    logic       hs;
    logic       vs;
    logic [9:0] col;
    logic [9:0] row;
    logic       act;
    logic       lck;
    logic       terr;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   edges = 0;

  // Reference model state: event times and counts since reset
  int   m_k, m_last_h, m_lines, m_good;
  bit   m_seen, m_line_bad, m_search, m_locked;
  logic m_prev_h, m_prev_v;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) edges <= 0;
    else        edges <= edges + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v, input int n);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, n, act, exp_v);
    end
  endtask

  task automatic model_reset();
    m_k = 0; m_last_h = -2; m_lines = 0; m_good = 0;
    m_seen = 0; m_line_bad = 0; m_search = 1; m_locked = 0;
    m_prev_h = 1'b1; m_prev_v = 1'b1;
  endtask

  // Drive one input cycle and predict the outputs one edge after it is sampled
  task automatic step(input logic h, input logic v);
    exp_t e;
    bit   hr, vr, line_err, frame_bad, err;
    int   col_n;
    H_Sync = h;
    V_Sync = v;
    hr = (h == 1'b1) && (m_prev_h == 1'b0);
    vr = (v == 1'b1) && (m_prev_v == 1'b0);
    line_err  = hr && m_seen && ((m_k - m_last_h) != TC);
    frame_bad = vr && ((m_lines != TR - 1) || m_line_bad);
    err = line_err || frame_bad;
    e.terr = (err && !m_search) ? 1'b1 : 1'b0;
    if (m_search) begin
      if (vr) begin m_search = 0; m_good = 0; end
    end else if (err) begin
      m_good = 0; m_locked = 0;
    end else if (vr) begin
      m_good++;
      if (m_good >= LF) m_locked = 1;
    end
    if (vr) m_line_bad = 0;
    else if (line_err) m_line_bad = 1;
    if (vr) m_lines = 0;
    else if (hr && m_lines < 1023) m_lines++;
    if (hr) begin m_last_h = m_k; m_seen = 1; end
    col_n = m_k - m_last_h;
    if (col_n > 1023) col_n = 1023;
    e.n   = m_k + 1;
    e.hs  = h;
    e.vs  = v;
    e.col = 10'(col_n);
    e.row = 10'(m_lines);
    e.lck = m_locked ? 1'b1 : 1'b0;
    e.act = (m_locked && col_n < AC && m_lines < AR) ? 1'b1 : 1'b0;
    sb_q.push_back(e);
    m_prev_h = h;
    m_prev_v = v;
    m_k++;
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    sb_q.delete();
    model_reset();
    for (int i = 0; i < 6; i++) begin
      H_Sync = 1'($urandom_range(0, 1));
      V_Sync = 1'($urandom_range(0, 1));
      @(negedge CLK);
    end
    H_Sync = 1'b1;
    V_Sync = 1'b1;
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  // Ideal generator frame with optional odd-length line; cycles before start_pos are skipped
  task automatic drive_frame(input int rows, input int bad_row, input int bad_len, input int start_pos);
    int pos, len;
    pos = 0;
    for (int r = 0; r < rows; r++) begin
      len = (r == bad_row) ? bad_len : TC;
      for (int c = 0; c < len; c++) begin
        if (pos >= start_pos) step(1'(c < AC), 1'(r < AR));
        pos++;
      end
    end
  endtask

  // Monitor: reset values while in reset, otherwise pop and compare per output cycle
  initial begin
    exp_t e;
    int   n;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        chk("rst_hsync_out", 32'(H_Sync_Out), 32'd1, -1);
        chk("rst_vsync_out", 32'(V_Sync_Out), 32'd1, -1);
        chk("rst_col", 32'(Col_Count), 32'd0, -1);
        chk("rst_row", 32'(Row_Count), 32'd0, -1);
        chk("rst_locked", 32'(Locked), 32'd0, -1);
        chk("rst_timing_err", 32'(Timing_Err), 32'd0, -1);
        chk("rst_active", 32'(Active), 32'd0, -1);
      end else begin
        n = edges - 1;
        while (sb_q.size() > 0 && sb_q[0].n < n) begin
          e = sb_q.pop_front();
          checks++;
          failures++;
          $display("FAIL missed_output cycle=%0d got=none expected=compare", e.n);
        end
        if (sb_q.size() > 0 && sb_q[0].n == n) begin
          e = sb_q.pop_front();
          chk("hsync_out", 32'(H_Sync_Out), 32'(e.hs), n);
          chk("vsync_out", 32'(V_Sync_Out), 32'(e.vs), n);
          chk("col_count", 32'(Col_Count), 32'(e.col), n);
          chk("row_count", 32'(Row_Count), 32'(e.row), n);
          chk("locked", 32'(Locked), 32'(e.lck), n);
          chk("active", 32'(Active), 32'(e.act), n);
          chk("timing_err", 32'(Timing_Err), 32'(e.terr), n);
        end
      end
    end
  end

  initial begin
    int sel;
    do_reset();
    repeat (5) step(1'b1, 1'b1);
    drive_frame(TR, -1, TC, $urandom_range(1, TR * TC - 1));
    repeat (4) drive_frame(TR, -1, TC, 0);
    // Short line while locked, then a good frame and a 7-line frame in acquire
    drive_frame(TR, $urandom_range(0, TR - 1), TC - 1, 0);
    drive_frame(TR, -1, TC, 0);
    drive_frame(7, -1, TC, 0);
    repeat (3) drive_frame(TR, -1, TC, 0);
    // Stuck sync, then recovery through normal edges
    repeat (1500) step(1'b1, 1'b1);
    repeat (4) drive_frame(TR, -1, TC, 0);
    for (int i = 0; i < 8; i++) begin
      sel = $urandom_range(0, 2);
      case (sel)
        0:       drive_frame(TR, -1, TC, 0);
        1:       drive_frame(TR, $urandom_range(0, TR - 1), $urandom_range(TC - 2, TC + 2), 0);
        default: drive_frame($urandom_range(TR - 1, TR + 1), -1, TC, 0);
      endcase
    end
    repeat (300) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    repeat (3) drive_frame(TR, -1, TC, 0);
    // Reset in the middle of a frame, then reacquire
    drive_frame(3, -1, TC, 0);
    do_reset();
    drive_frame(TR, -1, TC, $urandom_range(1, TR * TC - 1));
    repeat (4) drive_frame(TR, -1, TC, 0);
    repeat (3) @(negedge CLK);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0, edges);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_sync_to_count.md
Name: vga_sync_to_count

Overview:
- Receive-side counterpart of the VGA sync pulse generator. Takes H_Sync/V_Sync as produced by the generator and recovers column/row counts aligned to re-timed sync outputs.
- Verifies line and frame periods against the parameterised timing and reports lock and timing errors.
- Sits between the sync generator (or an external sync source) and pixel/pattern logic that needs coordinates.

Parameters:
- TOTAL_COLS, 800, clocks per line (H rise to H rise).
- TOTAL_ROWS, 525, lines per frame (V rise to V rise).
- ACTIVE_COLS, 640, leading columns of a line that are visible.
- ACTIVE_ROWS, 480, leading rows of a frame that are visible.
- LOCK_FRAMES, 2, consecutive good frames required to assert Locked (1..15).

Ports:
- CLK  in  1  pixel clock.
- RST_N  in  1  asynchronous active-low reset.
- H_Sync  in  1  horizontal sync: high during active columns, low during blanking.
- V_Sync  in  1  vertical sync: rising edge marks frame start.
- H_Sync_Out  out  1  H_Sync delayed 2 clocks.
- V_Sync_Out  out  1  V_Sync delayed 2 clocks.
- Col_Count  out  10  column index aligned to H_Sync_Out.
- Row_Count  out  10  row index aligned to V_Sync_Out.
- Active  out  1  Locked and Col_Count<ACTIVE_COLS and Row_Count<ACTIVE_ROWS.
- Locked  out  1  timing verified.
- Timing_Err  out  1  one-cycle pulse on period mismatch.

Behaviour:
- Reset values (async, RST_N=0): H_Sync_Out=1, V_Sync_Out=1, Col_Count=0, Row_Count=0, Locked=0, Timing_Err=0.
- Reset internal state: input stages h_d1/h_d2/v_d1/v_d2=1 (no spurious edge after release), state=SEARCH, good_cnt=0, frame_err=0, h_seen=0.
- Pipeline: h_d1<=H_Sync, h_d2<=h_d1; same for V. h_rise = h_d1 & ~h_d2; v_rise = v_d1 & ~v_d2. H_Sync_Out<=h_d1, V_Sync_Out<=v_d1. Input-to-output latency is 2 clocks.
- Column counter:
  - h_rise: Col_Count<=0.
  - Otherwise: increment, saturating at 1023.
  - Col_Count==0 coincides with the first high cycle of H_Sync_Out.
- Row counter (priority order):
  - v_rise: Row_Count<=0 (wins over a simultaneous h_rise).
  - Else h_rise: increment, saturating at 1023.
- Line check: on h_rise with h_seen=1, error if the pre-update Col_Count != TOTAL_COLS-1. Every h_rise sets h_seen=1.
- Frame check: on v_rise, the frame is bad if the pre-update Row_Count != TOTAL_ROWS-1 or frame_err=1. frame_err is sticky on any line error and is cleared on v_rise.
- Timing_Err: pulses 1 cycle after a line error or a bad frame, only in ACQUIRE/LOCKED. A line error and a bad frame in the same cycle produce a single pulse.
- FSM:
  - SEARCH: on first v_rise -> ACQUIRE, good_cnt=0. The partial frame before it is not evaluated.
  - ACQUIRE:
    - On v_rise with good frame: good_cnt+1; if it reaches LOCK_FRAMES -> LOCKED.
    - On line error or bad frame: good_cnt=0, stay in ACQUIRE.
  - LOCKED: on any line error or bad frame -> ACQUIRE, good_cnt=0. Locked deasserts on the same clock edge as the state change.
  - Locked = (state==LOCKED), registered. It rises on the same edge that zeroes Col/Row for the new frame.
- Active: combinational decode of registered Col_Count, Row_Count and Locked.
- Sync stuck (no edges): counters saturate at 1023, no pulses, state holds. Recovery happens through normal edges.
- Reset mid-frame: everything returns to reset values immediately; SEARCH restarts.

Test Plan:
- Reset/idle: RST_N low with sync inputs toggling -> all outputs at reset values. Release with H=V=1 -> no Timing_Err, state SEARCH.
- Nominal lock: TOTAL_COLS=10, ACTIVE_COLS=6, TOTAL_ROWS=6, ACTIVE_ROWS=4, LOCK_FRAMES=2, ideal stimulus.
  - Locked=1 at the 3rd V rise + 2 clocks, with Col=0, Row=0.
  - Col sequence 0..9, Row sequence 0..5.
  - Active=1 only for Col 0..5, Row 0..3.
  - Timing_Err never asserts.
- Alignment: single H rise at input cycle t -> H_Sync_Out rises at t+2 with Col_Count=0 in that same cycle.
- Short line while LOCKED: one line of 9 clocks -> Timing_Err pulses once, Locked drops. Locked returns after 2 further good frames plus the completion of the damaged frame.
- Wrong frame length: 7-line frame in ACQUIRE -> Timing_Err at its V rise, good_cnt resets, Locked stays 0.
- Stuck sync: hold H_Sync=1 for 1500 clocks -> Col_Count saturates at 1023, Row unchanged. The next H rise flags a line error.
